// File: rtl/rbs_pkg.sv
// Shared RBS ring definitions: default widths, the ring-word layout and
// the default register-map region bases used by the ring register slave.
package rbs_pkg;

    localparam int unsigned RBS_DATA_WIDTH = 32;
    localparam int unsigned RBS_ADDR_WIDTH = 30;
    localparam int unsigned RBS_SRC_WIDTH  = 2;
    localparam int unsigned RBS_TAG_WIDTH  = 8;

    localparam logic [RBS_DATA_WIDTH-1:0] RBS_BAD_ADDR_DATA = 32'hDEAD_BEEF;

    localparam int unsigned RBS_NUM_SW_REGS = 4;
    localparam int unsigned RBS_NUM_HW_REGS = 2;
    localparam int unsigned RBS_NUM_CNTRS   = 4;

    // Region bases of the local offset map: sw regs, then hw regs, then counters
    localparam int unsigned RBS_SW_BASE  = 0;
    localparam int unsigned RBS_HW_BASE  = RBS_SW_BASE + RBS_NUM_SW_REGS;
    localparam int unsigned RBS_CNT_BASE = RBS_HW_BASE + RBS_NUM_HW_REGS;
    localparam int unsigned RBS_MAP_END  = RBS_CNT_BASE + RBS_NUM_CNTRS;

    typedef struct packed {
        logic                      req;
        logic                      ack;
        logic                      rd_wr_l;
        logic [RBS_ADDR_WIDTH-1:0] addr;
        logic [RBS_DATA_WIDTH-1:0] data;
        logic [RBS_SRC_WIDTH-1:0]  src;
    } rbs_word_t;

endpackage

// File: rtl/rbs_sat_counter.sv
// Saturating event counter with a synchronous clear; an increment that
// coincides with a clear is kept, so the counter restarts at one.
module rbs_sat_counter #(
    parameter int unsigned C_WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               inc,
    input  logic               clr,
    output logic [C_WIDTH-1:0] count
);

    localparam logic [C_WIDTH-1:0] ONE = {{(C_WIDTH-1){1'b0}}, 1'b1};

    logic [C_WIDTH-1:0] count_r;

    // Count events, holding at all-ones instead of wrapping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= inc ? ONE : '0;
        end else if (inc && (count_r != '1)) begin
            count_r <= count_r + ONE;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/rbs_ring_reg_slave.sv
// RBS ring register node: one registered ring stage that services words tagged
// for this block. Optional macro RBS_CNTR_CLEAR_ON_READ_EN makes counter reads clear.
module rbs_ring_reg_slave
    import rbs_pkg::*;
#(
    parameter int unsigned                C_RBS_DATA_WIDTH = RBS_DATA_WIDTH,
    parameter int unsigned                C_RBS_ADDR_WIDTH = RBS_ADDR_WIDTH,
    parameter int unsigned                C_RBS_SRC_WIDTH  = RBS_SRC_WIDTH,
    parameter int unsigned                C_TAG_WIDTH      = RBS_TAG_WIDTH,
    parameter logic [C_TAG_WIDTH-1:0]     C_TAG            = 8'h10,
    parameter int unsigned                C_NUM_SW_REGS    = RBS_NUM_SW_REGS,
    parameter int unsigned                C_NUM_HW_REGS    = RBS_NUM_HW_REGS,
    parameter int unsigned                C_NUM_CNTRS      = RBS_NUM_CNTRS,
    parameter logic [C_RBS_DATA_WIDTH-1:0] C_BAD_ADDR_DATA = RBS_BAD_ADDR_DATA
) (
    input  logic                                      clk,
    input  logic                                      resetn,
    input  logic                                      reg_req_in,
    input  logic                                      reg_ack_in,
    input  logic                                      reg_rd_wr_L_in,
    input  logic [C_RBS_ADDR_WIDTH-1:0]               reg_addr_in,
    input  logic [C_RBS_DATA_WIDTH-1:0]               reg_data_in,
    input  logic [C_RBS_SRC_WIDTH-1:0]                reg_src_in,
    output logic                                      reg_req_out,
    output logic                                      reg_ack_out,
    output logic                                      reg_rd_wr_L_out,
    output logic [C_RBS_ADDR_WIDTH-1:0]               reg_addr_out,
    output logic [C_RBS_DATA_WIDTH-1:0]               reg_data_out,
    output logic [C_RBS_SRC_WIDTH-1:0]                reg_src_out,
    output logic [C_NUM_SW_REGS*C_RBS_DATA_WIDTH-1:0] sw_regs_out,
    input  logic [C_NUM_HW_REGS*C_RBS_DATA_WIDTH-1:0] hw_regs_in,
    input  logic [C_NUM_CNTRS-1:0]                    cntr_inc
);

    localparam int unsigned DW       = C_RBS_DATA_WIDTH;
    localparam int unsigned NUM_REGS = C_NUM_SW_REGS + C_NUM_HW_REGS + C_NUM_CNTRS;
    localparam int unsigned OFF_W    = $clog2(NUM_REGS);
    localparam int unsigned MID_W    = C_RBS_ADDR_WIDTH - C_TAG_WIDTH - OFF_W;
    localparam int unsigned HW_BASE  = C_NUM_SW_REGS;
    localparam int unsigned CNT_BASE = C_NUM_SW_REGS + C_NUM_HW_REGS;

    logic [C_TAG_WIDTH-1:0] tag_s;
    logic [MID_W-1:0]       mid_s;
    logic [31:0]            off_ext_s;
    logic                   hit_s;
    logic                   mid_zero_s;
    logic                   wr_hit_s;
    logic                   rd_hit_s;
    logic [DW-1:0]          rd_val_s;
    logic [C_NUM_SW_REGS-1:0] sw_we_s;
    logic [C_NUM_CNTRS-1:0] cnt_clr_s;
    logic [DW-1:0]          cnt_val_s [C_NUM_CNTRS];
    logic [DW-1:0]          sw_regs_r [C_NUM_SW_REGS];
    rbs_word_t              out_r;

    assign tag_s      = reg_addr_in[C_RBS_ADDR_WIDTH-1 -: C_TAG_WIDTH];
    assign mid_s      = reg_addr_in[C_RBS_ADDR_WIDTH-C_TAG_WIDTH-1:OFF_W];
    assign off_ext_s  = 32'(reg_addr_in[OFF_W-1:0]);
    assign mid_zero_s = (mid_s == {MID_W{1'b0}});
    assign hit_s      = reg_req_in & ~reg_ack_in & (tag_s == C_TAG);
    assign wr_hit_s   = hit_s & ~reg_rd_wr_L_in & mid_zero_s;
    assign rd_hit_s   = hit_s & reg_rd_wr_L_in & mid_zero_s;

    // Read mux over the local map; anything unmatched keeps the bad-address pattern
    always_comb begin
        rd_val_s = C_BAD_ADDR_DATA;
        for (int i = 0; i < int'(C_NUM_SW_REGS); i++) begin
            rd_val_s = (mid_zero_s && off_ext_s == 32'(i)) ? sw_regs_r[i] : rd_val_s;
        end
        for (int j = 0; j < int'(C_NUM_HW_REGS); j++) begin
            rd_val_s = (mid_zero_s && off_ext_s == 32'(HW_BASE + j)) ?
                       hw_regs_in[j*DW +: DW] : rd_val_s;
        end
        for (int k = 0; k < int'(C_NUM_CNTRS); k++) begin
            rd_val_s = (mid_zero_s && off_ext_s == 32'(CNT_BASE + k)) ? cnt_val_s[k] : rd_val_s;
        end
    end

    // Per-register write enables and counter instances
    genvar g;
    generate
        for (g = 0; g < C_NUM_SW_REGS; g++) begin : g_sw
            assign sw_we_s[g] = wr_hit_s & (off_ext_s == 32'(g));
            assign sw_regs_out[g*DW +: DW] = sw_regs_r[g];
        end
        for (g = 0; g < C_NUM_CNTRS; g++) begin : g_cnt
`ifdef RBS_CNTR_CLEAR_ON_READ_EN
            assign cnt_clr_s[g] = rd_hit_s & (off_ext_s == 32'(CNT_BASE + g));
`else
            assign cnt_clr_s[g] = 1'b0;
`endif
            rbs_sat_counter #(
                .C_WIDTH (DW)
            ) u_cnt (
                .clk    (clk),
                .resetn (resetn),
                .inc    (cntr_inc[g]),
                .clr    (cnt_clr_s[g]),
                .count  (cnt_val_s[g])
            );
        end
    endgenerate

    // Software register file, committed on the same edge that forwards the write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(C_NUM_SW_REGS); i++) begin
                sw_regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(C_NUM_SW_REGS); i++) begin
                if (sw_we_s[i]) begin
                    sw_regs_r[i] <= reg_data_in;
                end
            end
        end
    end

    // Ring pipeline stage: forward every word, marking and filling serviced ones
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_r <= '0;
        end else begin
            out_r.req     <= reg_req_in;
            out_r.ack     <= reg_ack_in | hit_s;
            out_r.rd_wr_l <= reg_rd_wr_L_in;
            out_r.addr    <= reg_addr_in;
            out_r.data    <= (hit_s && reg_rd_wr_L_in) ? rd_val_s : reg_data_in;
            out_r.src     <= reg_src_in;
        end
    end

    assign reg_req_out     = out_r.req;
    assign reg_ack_out     = out_r.ack;
    assign reg_rd_wr_L_out = out_r.rd_wr_l;
    assign reg_addr_out    = out_r.addr;
    assign reg_data_out    = out_r.data;
    assign reg_src_out     = out_r.src;

    // Reads of unmapped offsets in the hit path need no extra state
    logic unused_s;
    assign unused_s = rd_hit_s;

endmodule

// File: tb/tb_rbs_ring_reg_slave.sv
// Randomized bench for rbs_ring_reg_slave against a map-level reference model,
// with literal expectations for the directed scenarios.
module tb_rbs_ring_reg_slave;

`ifdef RBS_CNTR_CLEAR_ON_READ_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn;
    logic         reg_req_in, reg_ack_in, reg_rd_wr_L_in;
    logic [29:0]  reg_addr_in;
    logic [31:0]  reg_data_in;
    logic [1:0]   reg_src_in;
    logic         reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [29:0]  reg_addr_out;
    logic [31:0]  reg_data_out;
    logic [1:0]   reg_src_out;
    logic [127:0] sw_regs_out;
    logic [63:0]  hw_regs_in;
    logic [3:0]   cntr_inc;

    logic         sc_inc, sc_clr;
    logic [3:0]   sc_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_sw [4];
    longint      m_cnt [4];

    always #5 clk = ~clk;

    rbs_ring_reg_slave dut (
        .clk             (clk),
        .resetn          (resetn),
        .reg_req_in      (reg_req_in),
        .reg_ack_in      (reg_ack_in),
        .reg_rd_wr_L_in  (reg_rd_wr_L_in),
        .reg_addr_in     (reg_addr_in),
        .reg_data_in     (reg_data_in),
        .reg_src_in      (reg_src_in),
        .reg_req_out     (reg_req_out),
        .reg_ack_out     (reg_ack_out),
        .reg_rd_wr_L_out (reg_rd_wr_L_out),
        .reg_addr_out    (reg_addr_out),
        .reg_data_out    (reg_data_out),
        .reg_src_out     (reg_src_out),
        .sw_regs_out     (sw_regs_out),
        .hw_regs_in      (hw_regs_in),
        .cntr_inc        (cntr_inc)
    );

    rbs_sat_counter #(.C_WIDTH(4)) u_small (
        .clk    (clk),
        .resetn (resetn),
        .inc    (sc_inc),
        .clr    (sc_clr),
        .count  (sc_count)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sw[i]  = 32'h0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic drive(input logic req, input logic ack, input logic rd,
                         input logic [7:0] tag, input logic [17:0] mid, input logic [3:0] off,
                         input logic [31:0] data, input logic [1:0] src, input logic [3:0] inc);
        reg_req_in     = req;
        reg_ack_in     = ack;
        reg_rd_wr_L_in = rd;
        reg_addr_in    = {tag, mid, off};
        reg_data_in    = data;
        reg_src_in     = src;
        cntr_inc       = inc;
    endtask

    // Predict the word leaving the node, advance the model, clock, compare
    task automatic step();
        longint      addr, tag, mid, off, value;
        logic        hit;
        logic [66:0] exp_word;
        addr  = longint'(reg_addr_in);
        tag   = addr / (64'd1 << 22);
        mid   = (addr / 16) % (64'd1 << 18);
        off   = addr % 16;
        hit   = reg_req_in && !reg_ack_in && (tag == 64'h10);
        value = 64'hDEAD_BEEF;
        if (mid == 0 && off < 4) value = longint'(m_sw[off]);
        else if (mid == 0 && off < 6) value = longint'(hw_regs_in[(off-4)*32 +: 32]);
        else if (mid == 0 && off < 10) value = m_cnt[off-6];
        exp_word = {reg_req_in, (reg_ack_in | hit), reg_rd_wr_L_in, reg_addr_in,
                    (hit && reg_rd_wr_L_in) ? value[31:0] : reg_data_in, reg_src_in};
        if (hit && !reg_rd_wr_L_in && mid == 0 && off < 4) m_sw[off] = reg_data_in;
        for (int k = 0; k < 4; k++) begin
            if (CLR_EN && hit && reg_rd_wr_L_in && mid == 0 && off == 6 + k)
                m_cnt[k] = cntr_inc[k] ? 1 : 0;
            else if (cntr_inc[k] && m_cnt[k] < 64'hFFFF_FFFF)
                m_cnt[k] = m_cnt[k] + 1;
        end
        @(posedge clk);
        #1;
        chk("ring_word", {61'h0, reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out,
                          reg_data_out, reg_src_out}, {61'h0, exp_word});
        chk("sw_regs", sw_regs_out, {m_sw[3], m_sw[2], m_sw[1], m_sw[0]});
    endtask

    initial begin
        resetn = 1'b0;
        sc_inc = 1'b0;
        sc_clr = 1'b0;
        hw_regs_in = 64'h0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 18'h0, 4'h0, 32'h0, 2'd0, 4'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out,
                              reg_data_out, reg_src_out, sw_regs_out}, 128'h0);
        resetn = 1'b1;

        drive(1'b1, 1'b0, 1'b0, 8'h10, 18'h0, 4'd1, 32'hA5A5_0001, 2'd2, 4'h0);
        step();
        chk("wr_ack", reg_ack_out, 1'b1);
        chk("wr_sw1", sw_regs_out[63:32], 32'hA5A5_0001);

        drive(1'b1, 1'b0, 1'b1, 8'h10, 18'h0, 4'd1, 32'h0, 2'd1, 4'h0);
        step();
        chk("rd_sw1", {reg_ack_out, reg_data_out, reg_src_out}, {1'b1, 32'hA5A5_0001, 2'd1});

        drive(1'b1, 1'b0, 1'b1, 8'h11, 18'h0, 4'd0, 32'h0000_1234, 2'd3, 4'h0);
        step();
        chk("foreign_tag", {reg_ack_out, reg_data_out}, {1'b0, 32'h0000_1234});

        drive(1'b1, 1'b1, 1'b0, 8'h10, 18'h0, 4'd0, 32'h0000_FFFF, 2'd0, 4'h0);
        step();
        chk("acked_fwd", {reg_ack_out, reg_data_out}, {1'b1, 32'h0000_FFFF});
        chk("acked_no_wr", sw_regs_out, {32'h0, 32'h0, 32'hA5A5_0001, 32'h0});

        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 18'h0, 4'd0, 32'h0, 2'd0, 4'h1);
            step();
        end
        drive(1'b1, 1'b0, 1'b1, 8'h10, 18'h0, 4'd6, 32'h0, 2'd0, 4'h0);
        step();
        chk("cnt0_rd1", reg_data_out, 32'd5);
        drive(1'b1, 1'b0, 1'b1, 8'h10, 18'h0, 4'd6, 32'h0, 2'd0, 4'h1);
        step();
        chk("cnt0_rd2", reg_data_out, CLR_EN ? 32'd0 : 32'd5);
        drive(1'b1, 1'b0, 1'b1, 8'h10, 18'h0, 4'd6, 32'h0, 2'd0, 4'h0);
        step();
        chk("cnt0_rd3", reg_data_out, CLR_EN ? 32'd1 : 32'd6);

        drive(1'b1, 1'b0, 1'b1, 8'h10, 18'h0, 4'd12, 32'h0, 2'd0, 4'h0);
        step();
        chk("unmapped_off", {reg_ack_out, reg_data_out}, {1'b1, 32'hDEAD_BEEF});
        drive(1'b1, 1'b0, 1'b1, 8'h10, 18'h00100, 4'd0, 32'h0, 2'd0, 4'h0);
        step();
        chk("unmapped_mid", {reg_ack_out, reg_data_out}, {1'b1, 32'hDEAD_BEEF});

        hw_regs_in = 64'h1111_2222_0BAD_F00D;
        drive(1'b1, 1'b0, 1'b0, 8'h10, 18'h0, 4'd4, 32'h0000_0001, 2'd0, 4'h0);
        step();
        chk("ro_wr_ack", reg_ack_out, 1'b1);
        chk("ro_wr_nochg", sw_regs_out, {32'h0, 32'h0, 32'hA5A5_0001, 32'h0});
        drive(1'b1, 1'b0, 1'b1, 8'h10, 18'h0, 4'd4, 32'h0, 2'd0, 4'h0);
        step();
        chk("hw0_rd", reg_data_out, 32'h0BAD_F00D);

        for (int n = 0; n < 600; n++) begin
            logic [7:0]  tag;
            logic [17:0] mid;
            tag = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h10;
            mid = ($urandom_range(0, 7) == 0) ? 18'($urandom) : 18'h0;
            hw_regs_in = {$urandom, $urandom};
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), 1'($urandom),
                  tag, mid, 4'($urandom), $urandom, 2'($urandom), 4'($urandom));
            step();
        end

        drive(1'b1, 1'b0, 1'b0, 8'h10, 18'h0, 4'd0, 32'hCAFE_0000, 2'd1, 4'h0);
        step();
        drive(1'b1, 1'b0, 1'b1, 8'h10, 18'h0, 4'd0, 32'h0, 2'd1, 4'h0);
        #3;
        resetn = 1'b0;
        #1;
        chk("midstream_reset", {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out,
                                reg_data_out, reg_src_out, sw_regs_out}, 128'h0);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'h10, 18'h0, 4'd7, 32'h0, 2'd2, 4'h0);
        step();
        chk("cnt1_after_reset", reg_data_out, 32'd0);

        chk("small_reset", {124'h0, sc_count}, 128'h0);
        sc_inc = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("small_saturate", {124'h0, sc_count}, 128'hF);
        sc_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("small_clr_inc", {124'h0, sc_count}, 128'h1);
        sc_inc = 1'b0;
        @(posedge clk);
        #1;
        chk("small_clr", {124'h0, sc_count}, 128'h0);
        sc_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
